// File: rtl/gpx2_spi_slave.sv
// SPI mode-0 slave oversampled on i_clk, with a one-byte transmit holding register.
// Define GPX2_SPI_SLAVE_ABORT_EN to add o_frame_abort (pulses when a frame ends mid-byte).
module gpx2_spi_slave #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter logic [7:0]  DEFAULT_TXBYTE = 8'hFF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_spi_csn,
    input  logic       i_spi_dclk,
    input  logic       i_spi_mosi,
    output logic       o_spi_miso,
    input  logic [7:0] i_tx_byte,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_byte,
    output logic       o_busy
`ifdef GPX2_SPI_SLAVE_ABORT_EN
    ,
    output logic       o_frame_abort
`endif
);
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;

    logic [SYNC_STAGES-1:0] csn_sync;
    logic [SYNC_STAGES-1:0] dclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES:0]   flushed;
    logic                   csn_d;
    logic                   dclk_d;
    logic                   csn_s;
    logic                   dclk_s;
    logic                   mosi_s;
    logic                   csn_fall;
    logic                   dclk_rise;
    logic                   dclk_fall;

    state_t     state;
    logic       armed;
    logic [2:0] bit_cnt;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic [7:0] hold_byte;
    logic [7:0] next_tx;
    logic       hold_full;
    logic       msb_pending;

    assign csn_s      = csn_sync[SYNC_STAGES-1];
    assign dclk_s     = dclk_sync[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync[SYNC_STAGES-1];
    assign csn_fall   = csn_d & ~csn_s;
    assign dclk_rise  = ~dclk_d & dclk_s;
    assign dclk_fall  = dclk_d & ~dclk_s;
    assign next_tx    = hold_full ? hold_byte : DEFAULT_TXBYTE;
    assign o_tx_ready = ~hold_full;
    assign o_busy     = (state != ST_IDLE);

    // flushed marks when the synchronizers hold real pin samples rather than reset values,
    // so the reset value csn=1 cannot arm the block during a frame already in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            csn_sync  <= '1;
            dclk_sync <= '0;
            mosi_sync <= '0;
            csn_d     <= 1'b1;
            dclk_d    <= 1'b0;
            flushed   <= '0;
        end else begin
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], i_spi_csn};
            dclk_sync <= {dclk_sync[SYNC_STAGES-2:0], i_spi_dclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
            csn_d     <= csn_s;
            dclk_d    <= dclk_s;
            flushed   <= {flushed[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            armed       <= 1'b0;
            bit_cnt     <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            hold_byte   <= '0;
            hold_full   <= 1'b0;
            msb_pending <= 1'b0;
            o_spi_miso  <= 1'b0;
            o_rx_valid  <= 1'b0;
            o_rx_byte   <= '0;
`ifdef GPX2_SPI_SLAVE_ABORT_EN
            o_frame_abort <= 1'b0;
`endif
        end else begin
            o_rx_valid <= 1'b0;
`ifdef GPX2_SPI_SLAVE_ABORT_EN
            o_frame_abort <= 1'b0;
`endif
            if (flushed[SYNC_STAGES] && csn_s)
                armed <= 1'b1;
            if (i_tx_valid && !hold_full) begin
                hold_byte <= i_tx_byte;
                hold_full <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    o_spi_miso <= 1'b0;
                    if (csn_fall && armed)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    tx_shift    <= next_tx;
                    o_spi_miso  <= next_tx[7];
                    msb_pending <= 1'b0;
                    if (hold_full)
                        hold_full <= 1'b0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (dclk_rise) begin
                        rx_shift <= {rx_shift[6:0], mosi_s};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= ST_DONE;
                    end else if (dclk_fall) begin
                        // After a byte boundary the MSB of the freshly loaded byte goes out first.
                        if (msb_pending) begin
                            o_spi_miso  <= tx_shift[7];
                            msb_pending <= 1'b0;
                        end else begin
                            o_spi_miso <= tx_shift[6];
                            tx_shift   <= {tx_shift[6:0], 1'b0};
                        end
                    end
                end
                ST_DONE: begin
                    o_rx_byte   <= rx_shift;
                    o_rx_valid  <= 1'b1;
                    tx_shift    <= next_tx;
                    msb_pending <= 1'b1;
                    if (hold_full)
                        hold_full <= 1'b0;
                    state <= csn_s ? ST_IDLE : ST_SHIFT;
                end
                default: state <= ST_IDLE;
            endcase

            // Deselect overrides everything; a partial byte is simply dropped.
            if (csn_s) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
                if (state != ST_IDLE)
                    o_spi_miso <= 1'b0;
`ifdef GPX2_SPI_SLAVE_ABORT_EN
                o_frame_abort <= (state != ST_IDLE) && (bit_cnt != 3'd0);
`endif
            end
        end
    end
endmodule
